// File: rtl/asdpmem_reader_if.sv
// ============================================================================
// asdpmem_reader_if : command, B-port read and output-stream bundle for asdpmem_reader
// Rev 1.0
// ============================================================================
`default_nettype none

interface asdpmem_reader_if #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 32
);
  logic             start;
  logic [DEPTH-1:0] base;
  logic [DEPTH:0]   len;
  logic             busy;
  logic             done;
  logic [DEPTH-1:0] addrb;
  logic [WIDTH-1:0] dob;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    output start, base, len, dob, m_ready,
    input  busy, done, addrb, m_valid, m_data
  );

  modport slave (
    input  start, base, len, dob, m_ready,
    output busy, done, addrb, m_valid, m_data
  );
endinterface

`default_nettype wire

// File: rtl/asdpmem_reader.sv
// ============================================================================
// asdpmem_reader : burst reader from a 1-cycle-latency RAM port into a 2-deep stream FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module asdpmem_reader #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  asdpmem_reader_if.slave  bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [DEPTH-1:0] r_addr;
  logic [DEPTH:0]   r_remain;
  logic             r_inflight;
  logic [WIDTH-1:0] r_fifo [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             r_done;

  logic             w_pop;
  logic             w_issue;
  logic             w_accept;
  logic             w_last_pop;
  logic             w_busy;
  logic             w_done_nxt;
  logic [2:0]       w_occ;

  assign w_pop      = (r_count != 2'd0) && bus.m_ready;
  // Occupancy the FIFO will have once this cycle's landing read and pop settle.
  assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue    = (r_state == c_RUN) && (r_remain != '0) && (w_occ < 3'd2);
  assign w_accept   = (r_state == c_IDLE) && bus.start;
  assign w_last_pop = w_pop && (r_count == 2'd1) && !r_inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (bus.start && (bus.len != '0)) w_state_nxt = c_RUN;
      c_RUN:   if (w_issue && (r_remain == (DEPTH+1)'(1))) w_state_nxt = c_DRAIN;
      c_DRAIN: if (w_last_pop) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      c_IDLE:  w_done_nxt = bus.start && (bus.len == '0);
      c_RUN:   w_busy = 1'b1;
      c_DRAIN: begin
        w_busy     = 1'b1;
        w_done_nxt = w_last_pop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_remain   <= '0;
      r_inflight <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= w_done_nxt;
      r_inflight <= w_issue;
      if (w_accept) begin
        r_addr   <= bus.base;
        r_remain <= bus.len;
      end else if (w_issue) begin
        r_addr   <= r_addr + DEPTH'(1);
        r_remain <= r_remain - (DEPTH+1)'(1);
      end
      // dob is valid for the address issued on the previous edge.
      if (r_inflight) begin
        r_fifo[r_wptr] <= bus.dob;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign bus.addrb   = r_addr;
  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.m_valid = (r_count != 2'd0);
  assign bus.m_data  = r_fifo[r_rptr];

endmodule

`default_nettype wire
